// File: rtl/scan_roi_harness.sv
// scan_roi_harness: serial scan harness around a fuzzer ROI.
// Stimulus is shifted into din_shr and transferred to din on a strobe. After
// SETTLE_CYC idle cycles the ROI response is captured into dout_shr and
// shifted back out on sdo.
// The serial output is called sdo because "do" is a reserved word in
// SystemVerilog.
// Optional feature: define SCAN_ROI_HARNESS_SIG_EN to build a CRC-16-CCITT
// signature over the serial output stream; otherwise sig is tied to zero.
//
// state   | meaning
// IDLE    | shifting allowed, waiting for a strobe
// SETTLE  | din updated, counting down settle_cnt
// CAPTURE | sampling dout into dout_shr this cycle
module scan_roi_harness #(
   parameter int DIN_N      = 256,
   parameter int DOUT_N     = 256,
   parameter int SETTLE_CYC = 0,
   parameter int AUTO_STB   = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              di,
   input  logic              stb,
   output logic              sdo,
   output logic [DIN_N-1:0]  din,
   input  logic [DOUT_N-1:0] dout,
   output logic              busy,
   output logic              cap_done,
   output logic [15:0]       sig
);

   localparam int CNT_W = $clog2(DIN_N + 1);
   localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DIN_N - 1);
   localparam logic [7:0]       SETTLE_INIT = 8'(SETTLE_CYC);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      CAPTURE = 2'd2
   } state_t;

   state_t            state;
   logic [DIN_N-1:0]  din_shr;
   logic [DOUT_N-1:0] dout_shr;
   logic [CNT_W-1:0]  bit_cnt;
   logic [7:0]        settle_cnt;

   logic              shift_en;
   logic              strobe;
   logic [DIN_N-1:0]  din_shr_nxt;

   // din takes the shadow register including a bit shifted in on the strobe cycle
   assign shift_en    = (state == IDLE) & en;
   assign din_shr_nxt = shift_en ? {din_shr[DIN_N-2:0], di} : din_shr;
   assign strobe      = (state == IDLE) &
                        (stb | ((AUTO_STB != 0) & en & (bit_cnt == CNT_LAST)));

   assign sdo  = dout_shr[DOUT_N-1];
   assign busy = (state != IDLE);

   // Shift path, strobe transfer and settle/capture sequencing
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         din_shr    <= '0;
         dout_shr   <= '0;
         din        <= '0;
         bit_cnt    <= '0;
         settle_cnt <= '0;
         cap_done   <= 1'b0;
      end else begin
         cap_done <= 1'b0;
         case (state)
            IDLE: begin
               if (en) begin
                  din_shr  <= din_shr_nxt;
                  dout_shr <= {dout_shr[DOUT_N-2:0], din_shr[DIN_N-1]};
                  bit_cnt  <= (bit_cnt == CNT_LAST) ? '0 : bit_cnt + CNT_W'(1);
               end
               if (strobe) begin
                  din        <= din_shr_nxt;
                  bit_cnt    <= '0;
                  settle_cnt <= SETTLE_INIT;
                  state      <= (SETTLE_CYC > 0) ? SETTLE : CAPTURE;
               end
            end
            SETTLE: begin
               settle_cnt <= settle_cnt - 8'd1;
               if (settle_cnt == 8'd1)
                  state <= CAPTURE;
            end
            CAPTURE: begin
               dout_shr <= dout;
               cap_done <= 1'b1;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SCAN_ROI_HARNESS_SIG_EN
   // CRC-16-CCITT over each bit presented on sdo during an enabled shift
   always_ff @(posedge clk) begin
      if (!rst_n)
         sig <= 16'hFFFF;
      else if (state == CAPTURE)
         sig <= 16'hFFFF;
      else if (shift_en)
         sig <= {sig[14:0], 1'b0} ^ ((sig[15] ^ sdo) ? 16'h1021 : 16'h0000);
   end
`else
   assign sig = 16'h0000;
`endif

endmodule

// File: tb/tb_scan_roi_harness.sv
// Directed bench for scan_roi_harness: three instances cover manual strobe
// with settle, auto strobe without settle, and reset during settle.
module tb_scan_roi_harness;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

`ifdef SCAN_ROI_HARNESS_SIG_EN
   localparam bit SIG_ON = 1'b1;
`else
   localparam bit SIG_ON = 1'b0;
`endif

   // manual instance
   logic m_rst, m_en, m_di, m_stb, m_sdo, m_busy, m_cap;
   logic [7:0] m_din, m_dout;
   logic [15:0] m_sig;
   // auto-strobe instance
   logic a_rst, a_en, a_di, a_stb, a_sdo, a_busy, a_cap;
   logic [7:0] a_din, a_dout;
   logic [15:0] a_sig;
   // reset-during-settle instance
   logic r_rst, r_en, r_di, r_stb, r_sdo, r_busy, r_cap;
   logic [7:0] r_din, r_dout;
   logic [15:0] r_sig;

   scan_roi_harness #(.DIN_N(8), .DOUT_N(8), .SETTLE_CYC(2), .AUTO_STB(0)) u_man (
      .clk(clk), .rst_n(m_rst), .en(m_en), .di(m_di), .stb(m_stb), .sdo(m_sdo),
      .din(m_din), .dout(m_dout), .busy(m_busy), .cap_done(m_cap), .sig(m_sig));

   scan_roi_harness #(.DIN_N(8), .DOUT_N(8), .SETTLE_CYC(0), .AUTO_STB(1)) u_auto (
      .clk(clk), .rst_n(a_rst), .en(a_en), .di(a_di), .stb(a_stb), .sdo(a_sdo),
      .din(a_din), .dout(a_dout), .busy(a_busy), .cap_done(a_cap), .sig(a_sig));

   scan_roi_harness #(.DIN_N(8), .DOUT_N(8), .SETTLE_CYC(4), .AUTO_STB(0)) u_rst (
      .clk(clk), .rst_n(r_rst), .en(r_en), .di(r_di), .stb(r_stb), .sdo(r_sdo),
      .din(r_din), .dout(r_dout), .busy(r_busy), .cap_done(r_cap), .sig(r_sig));

   task automatic test_reset();
      logic [15:0] exp_sig;
      exp_sig = SIG_ON ? 16'hFFFF : 16'h0000;
      m_rst = 0; a_rst = 0; r_rst = 0;
      m_en = 1; m_di = 1; m_stb = 1; m_dout = 8'h00;
      a_en = 1; a_di = 1; a_stb = 1; a_dout = 8'h00;
      r_en = 1; r_di = 1; r_stb = 1; r_dout = 8'h00;
      repeat (2) @(negedge clk);
      checks++; if (m_din !== 8'h00) begin errors++; $display("FAIL reset_din got %h want 00", m_din); end
      checks++; if (m_sdo !== 1'b0) begin errors++; $display("FAIL reset_do got %b want 0", m_sdo); end
      checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", m_busy); end
      checks++; if (m_cap !== 1'b0) begin errors++; $display("FAIL reset_cap_done got %b want 0", m_cap); end
      checks++; if (m_sig !== exp_sig) begin errors++; $display("FAIL reset_sig got %h want %h", m_sig, exp_sig); end
      checks++; if (a_din !== 8'h00 || r_din !== 8'h00) begin errors++; $display("FAIL reset_din_other got %h/%h want 00", a_din, r_din); end
      m_en = 0; m_di = 0; m_stb = 0;
      a_en = 0; a_di = 0; a_stb = 0;
      r_en = 0; r_di = 0; r_stb = 0;
      m_rst = 1; a_rst = 1; r_rst = 1;
      @(negedge clk);
   endtask

   task automatic test_signature();
      logic [15:0] exp_sig;
      exp_sig = SIG_ON ? 16'hEFDF : 16'h0000;
      m_en = 1; m_di = 0;
      @(negedge clk);
      m_en = 0;
      checks++; if (m_sig !== exp_sig) begin errors++; $display("FAIL sig_first_shift got %h want %h", m_sig, exp_sig); end
   endtask

   task automatic test_manual_transfer();
      logic [7:0]  pat;
      logic [7:0]  resp;
      logic [15:0] crc;
      logic        fb;
      int          busy_cyc;
      int          cap_cnt;
      pat  = 8'hA5;
      resp = 8'h3C;
      m_dout = resp;
      for (int i = 7; i >= 0; i--) begin
         m_en = 1; m_di = pat[i];
         @(negedge clk);
      end
      m_en = 0; m_di = 0;
      checks++; if (m_din !== 8'h00) begin errors++; $display("FAIL man_din_before_stb got %h want 00", m_din); end
      m_stb = 1;
      @(negedge clk);
      checks++; if (m_din !== 8'hA5) begin errors++; $display("FAIL man_din got %h want a5", m_din); end
      busy_cyc = 0; cap_cnt = 0;
      for (int c = 0; c < 12; c++) begin
         if (m_busy) busy_cyc++;
         if (m_cap) cap_cnt++;
         if (m_busy) begin
            m_en = ~m_en; m_di = ~m_di; m_stb = ~m_stb;
         end else begin
            m_en = 0; m_di = 0; m_stb = 0;
         end
         @(negedge clk);
      end
      checks++; if (busy_cyc != 3) begin errors++; $display("FAIL man_busy_cycles got %0d want 3", busy_cyc); end
      checks++; if (cap_cnt != 1) begin errors++; $display("FAIL man_cap_pulses got %0d want 1", cap_cnt); end
      checks++; if (u_man.din_shr !== 8'hA5) begin errors++; $display("FAIL lock_din_shr got %h want a5", u_man.din_shr); end
      checks++; if (m_din !== 8'hA5) begin errors++; $display("FAIL lock_din got %h want a5", m_din); end
      checks++; if (u_man.dout_shr !== 8'h3C) begin errors++; $display("FAIL man_capture got %h want 3c", u_man.dout_shr); end
      crc = 16'hFFFF;
      for (int i = 7; i >= 0; i--) begin
         checks++; if (m_sdo !== resp[i]) begin errors++; $display("FAIL man_do_bit%0d got %b want %b", 7 - i, m_sdo, resp[i]); end
         fb  = crc[15] ^ resp[i];
         crc = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
         m_en = 1; m_di = 0;
         @(negedge clk);
      end
      m_en = 0;
      if (!SIG_ON) crc = 16'h0000;
      checks++; if (m_sig !== crc) begin errors++; $display("FAIL man_sig got %h want %h", m_sig, crc); end
   endtask

   task automatic test_auto_strobe();
      logic [7:0] pat;
      int busy_cyc;
      pat = 8'h5A;
      a_dout = 8'h81;
      for (int i = 7; i >= 1; i--) begin
         a_en = 1; a_di = pat[i];
         @(negedge clk);
         a_en = 0; a_di = ~a_di;
         @(negedge clk);
      end
      checks++; if (a_din !== 8'h00 || a_busy !== 1'b0) begin errors++; $display("FAIL auto_early got din %h busy %b want 00/0", a_din, a_busy); end
      checks++; if (u_auto.bit_cnt !== 4'd7) begin errors++; $display("FAIL auto_cnt7 got %0d want 7", u_auto.bit_cnt); end
      a_en = 1; a_di = pat[0];
      @(negedge clk);
      a_en = 0; a_di = 0;
      checks++; if (a_din !== 8'h5A) begin errors++; $display("FAIL auto_din got %h want 5a", a_din); end
      checks++; if (u_auto.bit_cnt !== 4'd0) begin errors++; $display("FAIL auto_cnt0 got %0d want 0", u_auto.bit_cnt); end
      checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL auto_busy got %b want 1", a_busy); end
      @(negedge clk);
      checks++; if (a_cap !== 1'b1 || a_busy !== 1'b0) begin errors++; $display("FAIL auto_cap got cap %b busy %b want 1/0", a_cap, a_busy); end
      checks++; if (a_sdo !== 1'b1) begin errors++; $display("FAIL auto_do got %b want 1", a_sdo); end
      a_en = 1; a_di = 1;
      @(negedge clk);
      a_en = 0; a_di = 0;
      busy_cyc = 0;
      for (int c = 0; c < 4; c++) begin
         if (a_busy) busy_cyc++;
         @(negedge clk);
      end
      checks++; if (busy_cyc != 0) begin errors++; $display("FAIL auto_ninth_busy got %0d want 0", busy_cyc); end
      checks++; if (a_din !== 8'h5A || u_auto.bit_cnt !== 4'd1) begin errors++; $display("FAIL auto_ninth got din %h cnt %0d want 5a/1", a_din, u_auto.bit_cnt); end
   endtask

   task automatic test_reset_settle();
      logic [7:0] pat;
      int cap_cnt;
      pat = 8'hC3;
      r_dout = 8'hFF;
      for (int i = 7; i >= 0; i--) begin
         r_en = 1; r_di = pat[i];
         @(negedge clk);
      end
      r_en = 0; r_di = 0;
      r_stb = 1;
      @(negedge clk);
      r_stb = 0;
      checks++; if (r_din !== 8'hC3 || r_busy !== 1'b1) begin errors++; $display("FAIL rs_transfer got din %h busy %b want c3/1", r_din, r_busy); end
      @(negedge clk);
      r_rst = 0;
      @(negedge clk);
      cap_cnt = 0;
      if (r_cap) cap_cnt++;
      checks++; if (r_busy !== 1'b0) begin errors++; $display("FAIL rs_busy got %b want 0", r_busy); end
      checks++; if (u_rst.dout_shr !== 8'h00 || r_sdo !== 1'b0) begin errors++; $display("FAIL rs_dout_shr got %h want 00", u_rst.dout_shr); end
      r_rst = 1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (r_cap) cap_cnt++;
      end
      checks++; if (cap_cnt != 0) begin errors++; $display("FAIL rs_cap_pulses got %0d want 0", cap_cnt); end
      checks++; if (u_rst.dout_shr !== 8'h00 || r_busy !== 1'b0) begin errors++; $display("FAIL rs_after got dout_shr %h busy %b want 00/0", u_rst.dout_shr, r_busy); end
   endtask

   initial begin
      test_reset();
      test_signature();
      test_manual_transfer();
      test_auto_strobe();
      test_reset_settle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
